// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time loader sitting in front of the CPU fetch stage. A framed byte
// stream (LEN_HI, LEN_LO, N x {HI, LO}, CHK) arrives over a valid/ready link.
// Big-endian 16-bit words are written to instruction memory at byte
// addresses 0, 2, 4, ... The CPU is released from reset only after the 8-bit
// checksum of the frame verifies.
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   start_i        single-cycle load request (honoured in IDLE, RUN, ERROR)
//   rx_data_i      incoming byte
//   rx_valid_i     rx_data_i valid
//   rx_ready_o     loader can accept a byte
//   imem_we_o      one-cycle instruction-memory write strobe
//   imem_addr_o    even byte address of the write
//   imem_wdata_o   instruction word
//   cpu_reset_o    active-low CPU reset (0 holds the CPU in reset)
//   busy_o         load in progress
//   done_o         last load succeeded, CPU running
//   error_o        last load failed
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [15:0] imem_addr_o,
  output logic [15:0] imem_wdata_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

  // 17 bits so that a DEPTH of 65536 would still compare correctly.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  hi_q, hi_d;      // holds LEN_HI, then each word's HI byte

  logic        rx_ready_q, rx_ready_d;
  logic        imem_we_q, imem_we_d;
  logic [15:0] imem_addr_q, imem_addr_d;
  logic [15:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [15:0] n_w;

  // rx_ready_q mirrors the current state, so it doubles as the accept gate.
  assign accept = rx_valid_i & rx_ready_q;
  assign n_w    = {hi_q, rx_data_i};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    hi_d         = hi_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start_i) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          hi_d    = rx_data_i;
          sum_d   = rx_data_i;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          sum_d = sum_q + rx_data_i;
          len_d = n_w;
          if (n_w == 16'd0 || {1'b0, n_w} > DEPTH_W) begin
            state_d = S_ERROR;
          end else begin
            idx_d   = 16'd0;
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data_i;
          sum_d   = sum_q + rx_data_i;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          sum_d        = sum_q + rx_data_i;
          imem_we_d    = 1'b1;
          imem_addr_d  = {idx_q[14:0], 1'b0};
          imem_wdata_d = {hi_q, rx_data_i};
          idx_d        = idx_q + 16'd1;
          state_d      = (idx_q == len_q - 16'd1) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data_i == sum_q) ? S_RUN : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the decoded next state, so
    // they change in the same cycle the state does.
    rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                  (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                  (state_d == S_CHECK);
    busy_d      = rx_ready_d;
    cpu_reset_d = (state_d == S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      hi_q         <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      hi_q         <= hi_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Scoreboard bench for program_loader. Frames are built as byte queues; a
// reference model derives the expected memory writes and the frame result
// directly from the frame bytes. Expected writes are queued when the LO byte
// is issued, and an independent monitor pops and compares on every imem_we.
// ---------------------------------------------------------------------------
module tb_program_loader;
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [15:0] imem_addr, imem_wdata;

  program_loader #(.DEPTH(DEPTH)) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .cpu_reset_o  (cpu_reset),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [7:0]  frame[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  logic [15:0] mon_addr, mon_data;
  always @(negedge clock) begin
    if (reset_n && imem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        mon_data = exp_data_q.pop_front();
        chk("write_addr", {16'd0, imem_addr}, {16'd0, mon_addr});
        chk("write_data", {16'd0, imem_wdata}, {16'd0, mon_data});
        $display("write addr=0x%04h data=0x%04h", imem_addr, imem_wdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_flags"}, {26'd0, rx_ready, imem_we, cpu_reset, busy, done, error}, 32'd0);
    chk({tag, "_addr"}, {16'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
  endtask

  task automatic do_start();
    @(negedge clock);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // {rx_ready, busy, cpu_reset, done, error} right after a start
    chk("after_start", {27'd0, rx_ready, busy, cpu_reset, done, error}, {27'd0, 5'b11000});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    @(negedge clock);
    rx_data = b;
    rx_valid = 1'b1;
    cnt = 0;
    while (rx_ready !== 1'b1 && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    if (rx_ready !== 1'b1) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clock);
  endtask

  // Sends the frame in 'frame' (up to stop bytes when stop >= 0) and checks
  // the final outcome when the frame is sent in full.
  task automatic run_frame(input int max_gap, input bit pulse_start, input int stop);
    int n, sent, gap;
    bit legal, ok;
    logic [7:0] s;
    n = int'({frame[0], frame[1]});
    legal = (n >= 1) && (n <= DEPTH);
    sent = legal ? frame.size() : 2;
    if (stop >= 0 && stop < sent) sent = stop;
    s = 8'd0;
    for (int i = 0; i < frame.size() - 1; i++) s = s + frame[i];
    ok = legal && (frame[frame.size() - 1] == s);
    $display("frame n=%0d bytes=%0d legal=%0b chk_ok=%0b sent=%0d", n, frame.size(), legal, ok, sent);
    for (int i = 0; i < sent; i++) begin
      if (i > 0) begin
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
          @(negedge clock);
          rx_valid = 1'b0;
        end
        if (pulse_start && i == 3) begin
          @(negedge clock);
          rx_valid = 1'b0;
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
        end
      end
      // Word k's LO byte sits at index 3+2k and lands at byte address 2k.
      if (legal && i >= 3 && (i % 2) == 1 && i <= 2 * n + 1) begin
        exp_addr_q.push_back(16'(i - 3));
        exp_data_q.push_back({frame[i - 1], frame[i]});
      end
      send_byte(frame[i]);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    if (sent == (legal ? frame.size() : 2)) begin
      // {rx_ready, busy, cpu_reset, done, error}
      chk("frame_result", {27'd0, rx_ready, busy, cpu_reset, done, error},
          {27'd0, 1'b0, 1'b0, ok, ok, !ok});
      if (!legal) chk("illegal_len_no_we", {31'd0, imem_we}, 32'd0);
    end
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [15:0] n16;
    logic [7:0] s;
    n16 = 16'(n);
    frame.delete();
    frame.push_back(n16[15:8]);
    frame.push_back(n16[7:0]);
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom));
      s = 8'd0;
      foreach (frame[i]) s = s + frame[i];
      frame.push_back(bad ? s + 8'($urandom_range(255, 1)) : s);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_reset_values("reset_state");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_no_start", {29'd0, rx_ready, busy, cpu_reset}, 32'd0);

    // Good load
    do_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    run_frame(0, 1'b0, -1);

    // Bad checksum
    do_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    run_frame(0, 1'b0, -1);

    // Illegal lengths
    do_start();
    frame = '{8'h00, 8'h00};
    run_frame(0, 1'b0, -1);
    do_start();
    frame = '{8'h01, 8'h01};
    run_frame(0, 1'b0, -1);

    // Backpressure plus an ignored mid-frame start
    do_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    run_frame(3, 1'b1, -1);

    // Reset mid-load after 00 02 12
    do_start();
    run_frame(0, 1'b0, 3);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_load_reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_after_reset", {29'd0, rx_ready, busy, cpu_reset}, 32'd0);
    do_start();
    run_frame(0, 1'b0, -1);

    // Reload from RUN (do_start checks cpu_reset drops the next cycle)
    do_start();
    frame = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int n;
      int kind;
      kind = $urandom_range(9, 0);
      if (kind == 0) n = 0;
      else if (kind == 1) n = $urandom_range(65535, DEPTH + 1);
      else n = $urandom_range(8, 1);
      build_frame(n, ($urandom_range(3, 0) == 0));
      do_start();
      run_frame($urandom_range(3, 0), 1'($urandom_range(1, 0)), -1);
    end

    // Full-capacity frame; last write lands at 2*(DEPTH-1)
    build_frame(DEPTH, 1'b0);
    do_start();
    run_frame(0, 1'b0, -1);

    repeat (4) @(negedge clock);
    chk("pending_writes", exp_addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the CPU's fetch stage. It receives a framed byte stream over a valid/ready link and assembles big-endian 16-bit instruction words. It writes them into instruction memory at even byte addresses starting at 0x0000, then releases the CPU from reset once the frame checksum verifies. The CPU's reset input is driven only by this block.

## Interface

Parameters:
- DEPTH, 256, instruction-memory capacity in 16-bit words; legal word counts are 1..DEPTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- start  in  1  single-cycle request to begin a load; honoured in IDLE, RUN, ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready on a rising edge.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  16  byte address of the write, always even.
- imem_wdata  out  16  instruction word.
- cpu_reset  out  1  active-low reset to the CPU; 0 holds the CPU in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded and the CPU is running.
- error  out  1  last load failed.

## Operation

- Frame format: LEN_HI, LEN_LO, then N words each as HI byte then LO byte, then CHK. N = {LEN_HI, LEN_LO}.
- CHK must equal the 8-bit sum (mod 256) of every preceding byte in the frame, including the length bytes.
- Each state is listed with its outputs, then its transitions:
  - IDLE: rx_ready=0, busy=0, cpu_reset=0. On start, clear done/error and go to LEN_HI.
  - LEN_HI: rx_ready=1, busy=1. On accept, latch the high byte, seed the sum, and go to LEN_LO.
  - LEN_LO: on accept, form N. If N==0 or N>DEPTH, go to ERROR. Otherwise clear the word index and go to DATA_HI.
  - DATA_HI: on accept, latch the high byte and go to DATA_LO.
  - DATA_LO: on accept, register the write: imem_addr = index*2, imem_wdata = {hi, byte}. Increment the index. If the index was N-1, go to CHECK; otherwise go to DATA_HI.
  - CHECK: on accept, compare the byte with the sum. On match, go to RUN. On mismatch, go to ERROR.
  - RUN: rx_ready=0, busy=0, done=1, cpu_reset=1. On start, go to LEN_HI with cpu_reset=0.
  - ERROR: rx_ready=0, busy=0, error=1, cpu_reset=0. On start, go to LEN_HI and clear error.
- Every accepted byte is added to the running sum before the CHECK comparison. The sum wraps mod 256.
- start is ignored while busy=1.
- Bytes presented while rx_ready=0 are not consumed. rx_valid may drop between bytes with no effect on state.
- Instruction memory is never written outside DATA_LO accepts. A failed frame may leave partially written words; the CPU stays in reset, so this is harmless.

## Timing

- All outputs are registered.
- Reset values: state IDLE, rx_ready 0, imem_we 0, imem_addr 0x0000, imem_wdata 0x0000, cpu_reset 0, busy 0, done 0, error 0. Internal index, length and sum are 0.
- start sampled high in cycle t: busy=1 and rx_ready=1 from t+1. cpu_reset=0 from t+1 when leaving RUN.
- Accepting a DATA_LO byte in cycle t: imem_we=1 during t+1 only, with address and data valid in the same cycle. imem_addr/imem_wdata hold until the next write.
- Maximum throughput: one byte per cycle, one memory write every 2 cycles.
- Accepting the CHK byte in cycle t: done=1, cpu_reset=1 and busy=0 from t+1 on a match; error=1 from t+1 on a mismatch.
- Accepting a LEN_LO byte that yields an illegal N in cycle t: error=1 from t+1. No imem_we is issued.
- Asserting reset at any point, including mid-frame: immediate return to reset values. The partial frame is discarded, and the next frame requires a new start.
- N==DEPTH: the last write goes to address 2*(DEPTH-1). The index never wraps.

## Test plan

- Good load, DEPTH=256: start, then bytes 00 02 12 34 AB CD C0. Required: writes 0x0000←0x1234 and 0x0002←0xABCD, then done=1, cpu_reset=1, busy=0, error=0.
- Bad checksum: the same frame with a final byte of C1. Required: two writes, error=1, done=0, cpu_reset stays 0.
- Illegal length: frame 00 00, and separately 01 01 (257 > DEPTH). Required: error=1 one cycle after the second byte, no imem_we, rx_ready=0.
- Backpressure: the good frame with rx_valid deasserted for 1–3 random cycles between bytes, and a start pulse issued mid-frame. Required: identical writes and result, with the start pulse ignored.
- Reset mid-load: reset asserted after 00 02 12. Required: all outputs at reset values immediately. A following start plus the full good frame succeeds with correct writes.
- Reload from RUN: after the good load, pulse start. Required: cpu_reset=0 the next cycle. Then load 00 01 FF FF FF. Required: write 0x0000←0xFFFF, and done=1 again.
